// File: rtl/ay_pkg.sv
// Shared types and the amplitude-to-level log table for the AY DAC mixer.
package ay_pkg;

  // 4-bit channel amplitude as presented on the amp port.
  typedef logic [3:0] amp_t;

  // 7-bit PWM level, 0..111 high cycles per frame.
  typedef logic [6:0] lvl_t;

  // Approximately logarithmic amplitude curve; the top entry fills a whole default frame.
  localparam lvl_t LOG_TABLE [16] = '{
    7'd0,  7'd1,  7'd2,  7'd3,  7'd4,  7'd5,  7'd6,  7'd7,
    7'd10, 7'd14, 7'd17, 7'd28, 7'd34, 7'd56, 7'd79, 7'd111
  };

  function automatic lvl_t amp_to_lvl(input amp_t a);
    return LOG_TABLE[a];
  endfunction

endpackage

// File: rtl/ay_sd_mod.sv
// First-order delta-sigma modulator: one output bit per cycle whose density tracks s_i / FULL.
module ay_sd_mod #(
  parameter int unsigned FULL = 333,
  parameter int unsigned SumW = $clog2(FULL + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [SumW-1:0] s_i,
  output logic            mix_o
);

  // Headroom for acc (< FULL) plus s_i (<= FULL) without wrapping.
  localparam int unsigned AccW = $clog2(2 * FULL) + 1;

  logic [AccW-1:0] acc_q, acc_d;
  logic [AccW-1:0] t;
  logic            mix_q, mix_d;

  // Add the input to the residue; emit a one and subtract FULL whenever it overflows.
  always_comb begin
    t     = acc_q + AccW'(s_i);
    mix_d = 1'b0;
    acc_d = t;
    if (t >= AccW'(FULL)) begin
      mix_d = 1'b1;
      acc_d = t - AccW'(FULL);
    end
  end

  // Residue and output bit registers, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q <= '0;
      mix_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      mix_q <= mix_d;
    end
  end

  assign mix_o = mix_q;

endmodule

// File: rtl/ay_dac_mix.sv
// AY-style DAC: per-channel gated PWM from log-scaled amplitudes plus a delta-sigma mix.
module ay_dac_mix
  import ay_pkg::*;
#(
  parameter int unsigned CHANNELS = 3,
  parameter int unsigned PERIOD   = 111
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [CHANNELS*4-1:0] amp,
  input  logic [CHANNELS-1:0]   in,
  output logic [CHANNELS-1:0]   out_ch,
  output logic                  out_mix,
  output logic                  frame
);

  localparam int unsigned FULL = CHANNELS * PERIOD;
  localparam int unsigned CntW = $clog2(PERIOD);
  localparam int unsigned CmpW = (CntW > 7) ? CntW : 7;
  localparam int unsigned SumW = $clog2(FULL + 1);

  // A frame shorter than the largest level would clip the top amplitudes.
  if (PERIOD < 111) begin : g_bad_period
    $error("ay_dac_mix: PERIOD must be at least 111");
  end
  if (CHANNELS < 1 || CHANNELS > 8) begin : g_bad_channels
    $error("ay_dac_mix: CHANNELS must be in 1..8");
  end

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            wrap;
  logic            frame_q;
  lvl_t            lvl_w [CHANNELS];
  logic [SumW-1:0] sum;

  assign wrap = (cnt_q == CntW'(PERIOD - 1));

  // Next frame position: wrap to zero after the last cycle of the frame.
  always_comb begin
    cnt_d = cnt_q + CntW'(1);
    if (wrap) begin
      cnt_d = '0;
    end
  end

  // Frame counter and wrap pulse; the pulse lines up with cnt = 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      frame_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      frame_q <= wrap;
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    lvl_t lvl_q;
    logic pwm_q;

    // Shadow level only updates on the wrap so a frame never sees a partial pulse.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        lvl_q <= '0;
      end else if (wrap) begin
        lvl_q <= amp_to_lvl(amp[g*4 +: 4]);
      end
    end

    // Gated PWM compare, registered to give one cycle of latency from the gate.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        pwm_q <= 1'b0;
      end else begin
        pwm_q <= (CmpW'(cnt_q) < CmpW'(lvl_q)) && in[g];
      end
    end

    assign lvl_w[g]  = lvl_q;
    assign out_ch[g] = pwm_q;
  end

  // Sum of the levels of all currently gated-on channels.
  always_comb begin
    sum = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (in[i]) begin
        sum = sum + SumW'(lvl_w[i]);
      end
    end
  end

  ay_sd_mod #(
    .FULL (FULL),
    .SumW (SumW)
  ) u_sd (
    .clk   (clk),
    .reset (reset),
    .s_i   (sum),
    .mix_o (out_mix)
  );

  assign frame = frame_q;

endmodule

// File: tb/tb_ay_dac_mix.sv
// Scoreboard bench for ay_dac_mix (3 channels, 111-cycle frame).
module tb_ay_dac_mix;

  localparam int Period = 111;
  localparam int Full   = 3 * Period;
  localparam int TBL [16] = '{0, 1, 2, 3, 4, 5, 6, 7, 10, 14, 17, 28, 34, 56, 79, 111};

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] amp;
  logic [2:0]  in;
  logic [2:0]  out_ch;
  logic        out_mix;
  logic        frame;

  typedef struct packed {
    logic [2:0] ch;
    logic       mix;
    logic       frm;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;

  // Reference model state: frame position, latched levels, mix residue.
  int m_cnt;
  int m_acc;
  int m_lvl [3];

  always #5 clk = ~clk;

  ay_dac_mix #(
    .CHANNELS (3),
    .PERIOD   (111)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .amp     (amp),
    .in      (in),
    .out_ch  (out_ch),
    .out_mix (out_mix),
    .frame   (frame)
  );

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, req, $time);
    end
  endtask

  // Advance the model across the next edge, queue its prediction, then cross the edge.
  task automatic tick();
    exp_t e;
    int   s;
    int   t;
    e = '0;
    if (reset) begin
      m_cnt = 0;
      m_acc = 0;
      for (int i = 0; i < 3; i++) m_lvl[i] = 0;
    end else begin
      s = 0;
      for (int i = 0; i < 3; i++) begin
        e.ch[i] = in[i] && (m_cnt < m_lvl[i]);
        if (in[i]) s += m_lvl[i];
      end
      t     = m_acc + s;
      e.mix = (t >= Full);
      m_acc = e.mix ? t - Full : t;
      e.frm = (m_cnt == Period - 1);
      if (m_cnt == Period - 1) begin
        for (int i = 0; i < 3; i++) m_lvl[i] = TBL[amp[4*i +: 4]];
      end
      m_cnt = (m_cnt + 1) % Period;
    end
    q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic wait_frame();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 300; k++) begin
      tick();
      if (frame) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("frame_timeout", 0, 1);
  endtask

  task automatic count_ch(input int ch, input int n, output int ones);
    ones = 0;
    repeat (n) begin
      tick();
      ones += int'(out_ch[ch]);
    end
  endtask

  task automatic count_mix(input int n, output int ones);
    ones = 0;
    repeat (n) begin
      tick();
      ones += int'(out_mix);
    end
  endtask

  // After reset release: time to first frame pulse and activity during that frame.
  task automatic first_frame();
    int n;
    int act;
    n   = 0;
    act = 0;
    for (int k = 0; k < 300; k++) begin
      tick();
      n++;
      if (out_ch != 3'b000) act++;
      if (frame) break;
    end
    check("first_frame_len", n, Period);
    check("first_frame_active", act, 0);
  endtask

  // Monitor: compare every registered output set against the queued prediction.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        mon_e = q.pop_front();
        check("outputs", int'({out_ch, out_mix, frame}), int'(mon_e));
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a;
    int b;
    m_cnt = 0;
    m_acc = 0;
    for (int i = 0; i < 3; i++) m_lvl[i] = 0;

    // Held in reset with everything driven on.
    reset = 1'b1;
    amp   = 12'hFFF;
    in    = 3'b111;
    repeat (5) tick();
    check("rst_out_ch", int'(out_ch), 0);
    check("rst_out_mix", int'(out_mix), 0);
    check("rst_frame", int'(frame), 0);

    // Release; first frame silent, amp 8 applies from the second.
    reset = 1'b0;
    amp   = 12'h008;
    in    = 3'b001;
    first_frame();
    count_ch(0, Period, a);
    check("amp8_highs", a, 10);

    amp = 12'h00F;
    wait_frame();
    count_ch(0, Period, a);
    check("ampF_highs", a, Period);

    amp = 12'h000;
    wait_frame();
    count_ch(0, Period, a);
    check("amp0_highs", a, 0);

    // Mid-frame amp change only affects the following frame.
    amp = 12'h008;
    wait_frame();
    count_ch(0, 50, a);
    amp = 12'h00D;
    count_ch(0, Period - 50, b);
    check("midframe_cur", a + b, 10);
    count_ch(0, Period, a);
    check("midframe_next", a, 56);

    // Channel 1 gate toggled every 20 cycles.
    amp = 12'h0F0;
    in  = 3'b010;
    wait_frame();
    for (int k = 0; k < 10; k++) begin
      in[1] = ~in[1];
      tick();
      check("ch1_follow", int'(out_ch[1]), int'(in[1]));
      repeat (19) tick();
    end

    // Mix density.
    amp = 12'hFFF;
    in  = 3'b111;
    wait_frame();
    count_mix(Period, a);
    check("mix_full", a, Period);
    amp = 12'h00F;
    in  = 3'b001;
    wait_frame();
    count_mix(3 * Period, a);
    check("mix_third", a, Period);

    // Random gates and amplitudes against the model.
    for (int k = 0; k < 1500; k++) begin
      in = 3'($urandom);
      if ((k % 37) == 0) amp = 12'($urandom);
      tick();
    end

    // Asynchronous reset pulse mid-frame with outputs active.
    amp = 12'hFFF;
    in  = 3'b111;
    wait_frame();
    repeat (70) tick();
    check("pre_rst_ch", int'(out_ch), 7);
    reset = 1'b1;
    #1;
    check("async_rst_ch", int'(out_ch), 0);
    check("async_rst_mix", int'(out_mix), 0);
    check("async_rst_frame", int'(frame), 0);
    tick();
    reset = 1'b0;
    first_frame();
    count_ch(0, Period, a);
    check("post_rst_ampF", a, Period);

    repeat (2) @(posedge clk);
    #2;
    check("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
